debug_unit_ctrl: RTL



---
 rtl/dbg_defs_pkg.sv | 45 ++++
 rtl/dbg_word_assembler.sv | 39 +++
 rtl/debug_unit_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/dbg_defs_pkg.sv
// Shared constants for the UART debug controller: command bytes, report status codes,
// FSM state encoding and the report byte mux.
package dbg_defs_pkg;

    localparam logic [7:0] CmdLoad = 8'h4C;
    localparam logic [7:0] CmdCont = 8'h43;
    localparam logic [7:0] CmdStep = 8'h53;

    localparam logic [7:0] StatusHalt    = 8'h00;
    localparam logic [7:0] StatusStep    = 8'h01;
    localparam logic [7:0] StatusTimeout = 8'h02;

    localparam logic [2:0] StIdle       = 3'd0;
    localparam logic [2:0] StLoadCnt    = 3'd1;
    localparam logic [2:0] StLoadByte   = 3'd2;
    localparam logic [2:0] StLoadWr     = 3'd3;
    localparam logic [2:0] StRun        = 3'd4;
    localparam logic [2:0] StStep       = 3'd5;
    localparam logic [2:0] StReport     = 3'd6;
    localparam logic [2:0] StReportWait = 3'd7;

    localparam int unsigned ReportLen = 9;

    // Report frame: status, then PC and cycle count, both MSB first.
    function automatic logic [7:0] report_byte(input logic [3:0]  idx,
                                               input logic [7:0]  status,
                                               input logic [31:0] pc,
                                               input logic [31:0] cnt);
        logic [7:0] b;
        case (idx)
            4'd0:    b = status;
            4'd1:    b = pc[31:24];
            4'd2:    b = pc[23:16];
            4'd3:    b = pc[15:8];
            4'd4:    b = pc[7:0];
            4'd5:    b = cnt[31:24];
            4'd6:    b = cnt[23:16];
            4'd7:    b = cnt[15:8];
            4'd8:    b = cnt[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/dbg_word_assembler.sv
// Packs four received bytes (MSB first) into a 32-bit instruction word.
module dbg_word_assembler (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_done
);

    logic [31:0] shift_q, shift_d;
    logic [1:0]  idx_q, idx_d;

    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        if (i_clr) begin
            idx_d = 2'd0;
        end else if (i_byte_valid) begin
            shift_d = {shift_q[23:0], i_byte};
            idx_d   = idx_q + 2'd1;
        end
    end

    assign o_word_done = i_byte_valid & ~i_clr & (idx_q == 2'd3);
    assign o_word      = shift_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: rtl/debug_unit_ctrl.sv
// UART-driven debug sequencer for the pipeline: load IMEM, run, single-step, report.
// Optional RUN watchdog is built when DBG_TIMEOUT_EN is defined.
module debug_unit_ctrl
    import dbg_defs_pkg::*;
#(
    parameter int unsigned NBITS      = 32,
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned RUN_LIMIT  = 1048576
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_valid,
    input  logic             i_tx_busy,
    output logic [7:0]       o_tx_data,
    output logic             o_tx_start,
    output logic             o_inst_mem_wr_en,
    output logic [NBITS-1:0] o_inst_mem_addr,
    output logic [NBITS-1:0] o_inst_mem_data,
    output logic             o_pipe_en,
    input  logic             i_halt,
    input  logic [NBITS-1:0] i_pc,
    output logic [2:0]       o_state
);

    logic [2:0]       state_q, state_d;
    logic [NBITS-1:0] words_q, words_d, widx_q, widx_d;
    logic [31:0]      cycle_q, cycle_d, pc_snap_q, pc_snap_d, cnt_snap_q, cnt_snap_d;
    logic [7:0]       status_q, status_d, tx_data_q, tx_data_d;
    logic [3:0]       tx_idx_q, tx_idx_d;
    logic             tx_start_q, tx_start_d, tx_hold_q, tx_hold_d;
    logic             pipe_en, cycle_clr, enter_report;
    logic             asm_valid, asm_clr, word_done;
    logic [31:0]      asm_word;
`ifdef DBG_TIMEOUT_EN
    logic [31:0]      wd_q, wd_d;
`endif

    assign asm_clr   = (state_q != StLoadByte);
    assign asm_valid = i_rx_valid & (state_q == StLoadByte);

    dbg_word_assembler u_word_asm (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clr        (asm_clr),
        .i_byte_valid (asm_valid),
        .i_byte       (i_rx_data),
        .o_word       (asm_word),
        .o_word_done  (word_done)
    );

    always_comb begin
        state_d      = state_q;
        words_d      = words_q;
        widx_d       = widx_q;
        status_d     = status_q;
        pc_snap_d    = pc_snap_q;
        cnt_snap_d   = cnt_snap_q;
        tx_data_d    = tx_data_q;
        tx_idx_d     = tx_idx_q;
        tx_start_d   = 1'b0;
        tx_hold_d    = tx_hold_q;
        pipe_en      = 1'b0;
        cycle_clr    = 1'b0;
        enter_report = 1'b0;
`ifdef DBG_TIMEOUT_EN
        wd_d         = wd_q;
`endif
        case (state_q)
            StIdle: begin
                if (i_rx_valid) begin
                    case (i_rx_data)
                        CmdLoad: state_d = StLoadCnt;
                        CmdCont: begin
                            state_d = StRun;
`ifdef DBG_TIMEOUT_EN
                            wd_d    = '0;
`endif
                        end
                        CmdStep: state_d = StStep;
                        default: state_d = StIdle;
                    endcase
                end
            end
            StLoadCnt: begin
                if (i_rx_valid) begin
                    if (i_rx_data == 8'h00) begin
                        state_d = StIdle;
                    end else begin
                        words_d = (NBITS'(i_rx_data) > NBITS'(IMEM_DEPTH)) ?
                                  NBITS'(IMEM_DEPTH) : NBITS'(i_rx_data);
                        widx_d  = '0;
                        state_d = StLoadByte;
                    end
                end
            end
            StLoadByte: begin
                if (word_done) state_d = StLoadWr;
            end
            StLoadWr: begin
                widx_d = widx_q + NBITS'(1);
                if (widx_d == words_q) begin
                    state_d   = StIdle;
                    cycle_clr = 1'b1;
                end else begin
                    state_d = StLoadByte;
                end
            end
            StRun: begin
                pipe_en = ~i_halt;
                if (i_halt) begin
                    enter_report = 1'b1;
                    status_d     = StatusHalt;
                end
`ifdef DBG_TIMEOUT_EN
                else begin
                    wd_d = wd_q + 32'd1;
                    if (wd_d == 32'(RUN_LIMIT)) begin
                        enter_report = 1'b1;
                        status_d     = StatusTimeout;
                    end
                end
`endif
            end
            StStep: begin
                pipe_en      = 1'b1;
                enter_report = 1'b1;
                status_d     = i_halt ? StatusHalt : StatusStep;
            end
            StReport: begin
                if (!i_tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = report_byte(tx_idx_q, status_q, pc_snap_q, cnt_snap_q);
                    tx_hold_d  = 1'b1;
                    state_d    = StReportWait;
                end
            end
            StReportWait: begin
                // First cycle after a start: UART busy may not have risen yet.
                if (tx_hold_q) begin
                    tx_hold_d = 1'b0;
                end else if (!i_tx_busy) begin
                    if (tx_idx_q == 4'(ReportLen - 1)) begin
                        tx_idx_d = '0;
                        state_d  = StIdle;
                    end else begin
                        tx_idx_d = tx_idx_q + 4'd1;
                        state_d  = StReport;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        cycle_d = cycle_clr ? 32'd0 : cycle_q + {31'd0, pipe_en};
        if (enter_report) begin
            state_d    = StReport;
            pc_snap_d  = i_pc[31:0];
            cnt_snap_d = cycle_d;
            tx_idx_d   = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q    <= StIdle;
            words_q    <= '0;
            widx_q     <= '0;
            cycle_q    <= '0;
            pc_snap_q  <= '0;
            cnt_snap_q <= '0;
            status_q   <= '0;
            tx_data_q  <= '0;
            tx_idx_q   <= '0;
            tx_start_q <= 1'b0;
            tx_hold_q  <= 1'b0;
`ifdef DBG_TIMEOUT_EN
            wd_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            words_q    <= words_d;
            widx_q     <= widx_d;
            cycle_q    <= cycle_d;
            pc_snap_q  <= pc_snap_d;
            cnt_snap_q <= cnt_snap_d;
            status_q   <= status_d;
            tx_data_q  <= tx_data_d;
            tx_idx_q   <= tx_idx_d;
            tx_start_q <= tx_start_d;
            tx_hold_q  <= tx_hold_d;
`ifdef DBG_TIMEOUT_EN
            wd_q       <= wd_d;
`endif
        end
    end

    assign o_state          = state_q;
    assign o_pipe_en        = pipe_en;
    assign o_tx_start       = tx_start_q;
    assign o_tx_data        = tx_data_q;
    assign o_inst_mem_wr_en = (state_q == StLoadWr);
    assign o_inst_mem_addr  = o_inst_mem_wr_en ? {widx_q[NBITS-3:0], 2'b00} : '0;
    assign o_inst_mem_data  = o_inst_mem_wr_en ? NBITS'(asm_word) : '0;

endmodule
